bank_router: RTL
================

BANK_ROUTER -- requirements
Module: bank_router

Interface
REQ-001 SHALL have parameter DW, default 8: width of one data word.
REQ-002 SHALL have parameter NBANK, default 3: number of line-buffer banks, 2..16, not limited to 4.
REQ-003 SHALL have parameter BUFW, default 32: words per line.
REQ-004 SHALL have localparam BW = $clog2(NBANK): bank index width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a job.
REQ-008 SHALL have port mode, input, 1: 0 = manual, bank taken from bank_sel each line; 1 = rotate, internal pointer used; sampled at start.
REQ-009 SHALL have port bank_base, input, BW: first bank in rotate mode; sampled at start.
REQ-010 SHALL have port bank_sel, input, BW: bank for the current line in manual mode.
REQ-011 SHALL have port nlines, input, 16: lines in the job; sampled at start.
REQ-012 SHALL have port idata, input, [NBANK][BUFW] x DW: all bank lines.
REQ-013 SHALL have port in_valid, input, 1: upstream asserts that idata is valid.
REQ-014 SHALL have port in_ready, output, 1: router accepts a line this cycle.
REQ-015 SHALL have port odata, output, [BUFW] x DW: registered selected line.
REQ-016 SHALL have port out_valid, output, 1: odata is valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts odata.
REQ-018 SHALL have port out_bank, output, BW: bank that odata came from.
REQ-019 SHALL have ports busy, done and err, output, 1 bit each: job active; one-cycle pulse at job end; sticky range error.

Function
REQ-020 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE: start in IDLE goes to RUN, or to DONE if nlines==0; start outside IDLE is ignored.
REQ-021 SHALL assert in_ready = (state==RUN) && (lines accepted < nlines) && (!out_valid || out_ready).
REQ-022 SHALL perform a transfer when in_valid && in_ready: at the next edge odata <= idata[sel], out_bank <= sel, out_valid <= 1, accept counter +1; latency is 1 cycle.
REQ-023 SHALL use sel = bank_sel in manual mode and the rotate pointer in rotate mode.
REQ-024 SHALL, in rotate mode, load the pointer from bank_base at start and advance it after each transfer, wrapping NBANK-1 -> 0.
REQ-025 SHALL clear out_valid when out_ready is high and no transfer occurs that cycle; on a simultaneous pop and transfer, out_valid stays 1 and odata takes the new line.
REQ-026 SHALL hold odata and out_bank stable while out_valid && !out_ready.
REQ-027 SHALL leave RUN for DONE in the cycle after the nlines-th line is popped (out_valid && out_ready), so the output register is empty.
REQ-028 SHALL stay in DONE for one cycle with done=1, then return to IDLE.
REQ-029 SHALL hold busy=1 in RUN and DONE.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-job, force state IDLE, set out_valid, busy, done, err and in_ready to 0, and clear odata, out_bank, the pointer and the counter to 0.
REQ-031 SHALL drop any in-flight line on reset and emit no done for it.

Configuration
REQ-032 SHALL gate range checking with macro BANK_ROUTER_RANGE_CHK_EN.
REQ-033 SHALL, when the macro is defined, set err when bank_base >= NBANK at start (rotate) or when bank_sel >= NBANK at a transfer (manual); that transfer still completes with odata all zero, and err is cleared only by reset or the next start.
REQ-034 SHALL, when the macro is undefined, tie err to 0 and select bank 0 for any out-of-range index.

Structure
REQ-035 SHALL place the FSM state enum (IDLE/RUN/DONE) and the mode encoding in package bank_router_pkg.
REQ-036 SHALL implement the NBANK:1 line selection as sub-module bank_sel_mux (combinational, parameters DW/NBANK/BUFW), instantiated once.

Verification
REQ-037 SHALL cover: NBANK=3, rotate, base=1, nlines=5, in_valid and out_ready always 1 -> out_bank sequence 1,2,0,1,2; done 1 cycle after the 5th pop.
REQ-038 SHALL cover: manual mode, bank_sel=2, out_ready low for 3 cycles -> odata held, in_ready=0, no line lost or duplicated.
REQ-039 SHALL cover: start with nlines=0 -> done pulses in the 2nd cycle, out_valid never 1.
REQ-040 SHALL cover: with the macro defined and NBANK=3, manual bank_sel=3 -> err=1, odata all zero, job completes.
REQ-041 SHALL cover: rst_n low during RUN after 2 of 4 lines -> all outputs 0 next cycle; a new start then runs 4 clean lines.
REQ-042 SHALL cover: start pulsed during RUN -> ignored, line count unchanged.

Source files
------------

// File: rtl/bank_router_pkg.sv
// Shared types for bank_router: controller state and job mode encodings.
package bank_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_ROTATE = 1'b1
  } mode_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bank_router_sel_mux.sv
// NBANK:1 line selector. An index with no matching bank yields bank 0 and raises oor_o.
module bank_sel_mux #(
  parameter int DW    = 8,
  parameter int NBANK = 3,
  parameter int BUFW  = 32,
  localparam int BW   = $clog2(NBANK)
) (
  input  logic [NBANK-1:0][BUFW-1:0][DW-1:0] idata_i,
  input  logic [BW-1:0]                      sel_i,
  output logic [BUFW-1:0][DW-1:0]            line_o,
  output logic                               oor_o
);

  logic [NBANK-1:0] hit;

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_hit
    assign hit[gi] = (sel_i == BW'(gi));
  end

  always_comb begin
    line_o = idata_i[0];
    for (int b = 0; b < NBANK; b++) begin
      if (hit[b]) line_o = idata_i[b];
    end
  end

  assign oor_o = ~|hit;

endmodule

// File: rtl/bank_router.sv
// Routes one bank line per handshake into a single-entry output register.
// Range checking (err, zeroed line on bad index) is enabled by BANK_ROUTER_RANGE_CHK_EN.
module bank_router
  import bank_router_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NBANK = 3,
  parameter int BUFW  = 32,
  localparam int BW   = $clog2(NBANK)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               mode,
  input  logic [BW-1:0]                      bank_base,
  input  logic [BW-1:0]                      bank_sel,
  input  logic [CNT_W-1:0]                   nlines,
  input  logic [NBANK-1:0][BUFW-1:0][DW-1:0] idata,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [BUFW-1:0][DW-1:0]            odata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BW-1:0]                      out_bank,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [CNT_W-1:0]        nlines_q, nlines_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        pop_q, pop_d;
  logic [BW-1:0]           ptr_q, ptr_d;
  logic [BUFW-1:0][DW-1:0] odata_q, odata_d;
  logic [BW-1:0]           obank_q, obank_d;
  logic                    ovalid_q, ovalid_d;
  logic                    err_q, err_d;

  logic [BW-1:0]           sel;
  logic [BUFW-1:0][DW-1:0] mux_line;
  logic [BUFW-1:0][DW-1:0] line_sel;
  logic [BW-1:0]           bank_eff;
  logic                    sel_oor;
  logic                    xfer;
  logic                    pop;

  assign sel = (mode_q == MODE_ROTATE) ? ptr_q : bank_sel;

  bank_sel_mux #(
    .DW    (DW),
    .NBANK (NBANK),
    .BUFW  (BUFW)
  ) u_mux (
    .idata_i (idata),
    .sel_i   (sel),
    .line_o  (mux_line),
    .oor_o   (sel_oor)
  );

`ifdef BANK_ROUTER_RANGE_CHK_EN
  assign line_sel = sel_oor ? '0 : mux_line;
  assign bank_eff = sel;
`else
  assign line_sel = mux_line;
  assign bank_eff = sel_oor ? '0 : sel;
`endif

  assign in_ready = (state_q == RUN) && (acc_q < nlines_q) && (!ovalid_q || out_ready);
  assign xfer     = in_valid && in_ready;
  assign pop      = ovalid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    nlines_d = nlines_q;
    acc_d    = acc_q;
    pop_d    = pop_q;
    ptr_d    = ptr_q;
    odata_d  = odata_q;
    obank_d  = obank_q;
    ovalid_d = ovalid_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode_e'(mode);
          nlines_d = nlines;
          acc_d    = '0;
          pop_d    = '0;
          ptr_d    = bank_base;
          err_d    = 1'b0;
`ifdef BANK_ROUTER_RANGE_CHK_EN
          if (mode && (int'(bank_base) >= NBANK)) err_d = 1'b1;
`endif
          state_d  = (nlines == '0) ? DONE : RUN;
        end
      end
      // Finish only once the last line has left the output register.
      RUN: begin
        if (pop && ((pop_q + 16'd1) == nlines_q)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) pop_d = pop_q + 16'd1;

    if (xfer) begin
      odata_d  = line_sel;
      obank_d  = bank_eff;
      ovalid_d = 1'b1;
      acc_d    = acc_q + 16'd1;
      if (mode_q == MODE_ROTATE) begin
        if (int'(ptr_q) >= NBANK - 1) ptr_d = '0;
        else                          ptr_d = ptr_q + BW'(1);
      end
`ifdef BANK_ROUTER_RANGE_CHK_EN
      if ((mode_q == MODE_MANUAL) && sel_oor) err_d = 1'b1;
`endif
    end else if (pop) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MANUAL;
      nlines_q <= '0;
      acc_q    <= '0;
      pop_q    <= '0;
      ptr_q    <= '0;
      odata_q  <= '0;
      obank_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      nlines_q <= nlines_d;
      acc_q    <= acc_d;
      pop_q    <= pop_d;
      ptr_q    <= ptr_d;
      odata_q  <= odata_d;
      obank_q  <= obank_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  assign odata     = odata_q;
  assign out_bank  = obank_q;
  assign out_valid = ovalid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule
